weight_ram_arbiter: RTL and testbench

Single-port scheduler for the feed-forward network's 256-bit weight RAM. The RAM is synchronous-write with a registered read address. The block shares it between two requesters: a host loader issuing single-word writes, and the inference engine issuing burst reads of consecutive weight rows. It generates all RAM address, data and write-enable signals, sequences burst addresses, returns read data with a valid strobe, and guarantees the loader forward progress during long bursts.

---
 rtl/weight_ram_arbiter.sv | 158 +++++++++++++++
 tb/tb_weight_ram_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_ram_arbiter.sv
// Single-port weight RAM scheduler. It shares the RAM between a host loader
// that issues single-word writes and the inference engine that issues burst reads.
// Read data returns one cycle after issue with a valid strobe.
// During a burst, grants alternate so the loader never waits more than one cycle.

`timescale 1ns / 1ps

module weight_ram_arbiter #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  // loader write port
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_gnt,
  // burst read port
  input  logic              brst_start,
  input  logic [ADDR_W-1:0] brst_base,
  input  logic [ADDR_W-1:0] brst_len_m1,
  output logic              brst_busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              brst_done,
  // RAM side
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic {StIdle, StBurst} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] beat_q, beat_d;
  // All beats issued; waiting one cycle for the final beat's data.
  logic              drain_q, drain_d;
  // 1 = loader was served last, 0 = burst read was served last.
  logic              last_wr_q, last_wr_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;

  logic              rd_issue;
  logic              rd_final;

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      base_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      drain_q    <= 1'b0;
      last_wr_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      drain_q    <= drain_d;
      last_wr_q  <= last_wr_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

  // Arbitration, burst sequencing and RAM control.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    beat_d    = beat_q;
    drain_d   = drain_q;
    last_wr_d = last_wr_q;
    ld_gnt    = 1'b0;
    ram_we    = 1'b0;
    ram_a     = '0;
    rd_issue  = 1'b0;
    rd_final  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ld_req) begin
          ld_gnt    = 1'b1;
          ram_we    = 1'b1;
          ram_a     = ld_addr;
          last_wr_d = 1'b1;
        end
        // A same-cycle write is still performed; the first read issues next cycle.
        if (brst_start) begin
          base_d  = brst_base;
          len_d   = brst_len_m1;
          beat_d  = '0;
          drain_d = 1'b0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (drain_q) begin
          // No read to issue, so the loader may use the port.
          if (ld_req) begin
            ld_gnt    = 1'b1;
            ram_we    = 1'b1;
            ram_a     = ld_addr;
            last_wr_d = 1'b1;
          end
          drain_d = 1'b0;
          state_d = StIdle;
        end else if (ld_req && !last_wr_q) begin
          ld_gnt    = 1'b1;
          ram_we    = 1'b1;
          ram_a     = ld_addr;
          last_wr_d = 1'b1;
        end else begin
          rd_issue  = 1'b1;
          ram_a     = base_q + beat_q;  // wraps mod 2^ADDR_W
          beat_d    = beat_q + AddrOne;
          last_wr_d = 1'b0;
          if (beat_q == len_q) begin
            rd_final = 1'b1;
            drain_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Keep the RAM quiet while reset is held.
    if (reset) begin
      ld_gnt   = 1'b0;
      ram_we   = 1'b0;
      ram_a    = '0;
      rd_issue = 1'b0;
      rd_final = 1'b0;
    end
  end

  // Read return strobes track the read issued in the previous cycle.
  always_comb begin
    rd_valid_d = rd_issue;
    done_d     = rd_issue && rd_final;
  end

  assign brst_busy = (state_q == StBurst);
  assign rd_valid  = rd_valid_q;
  assign brst_done = done_q;
  assign rd_data   = ram_q;
  assign ram_d     = ld_data;

endmodule

// File: tb/tb_weight_ram_arbiter.sv
// Directed bench for weight_ram_arbiter with a behavioural registered-read RAM.

`timescale 1ns / 1ps

module tb_weight_ram_arbiter;

  localparam int unsigned DW = 256;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_gnt;
  logic          brst_start;
  logic [AW-1:0] brst_base;
  logic [AW-1:0] brst_len_m1;
  logic          brst_busy;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          brst_done;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  logic [DW-1:0] mem [16];

  int n_vec  = 0;
  int n_miss = 0;

  weight_ram_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_gnt      (ld_gnt),
    .brst_start  (brst_start),
    .brst_base   (brst_base),
    .brst_len_m1 (brst_len_m1),
    .brst_busy   (brst_busy),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .brst_done   (brst_done),
    .ram_a       (ram_a),
    .ram_d       (ram_d),
    .ram_we      (ram_we),
    .ram_q       (ram_q)
  );

  always #5 clk = ~clk;

  // Synchronous-write RAM with registered read address.
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_d;
    ram_q <= mem[ram_a];
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Burst observation results, offsets relative to the brst_start cycle.
  logic [DW-1:0] beats[$];
  logic [AW-1:0] addrs[$];
  int            gnt_pos[$];
  int            ndone, done_at, busy_low_at, first_valid_at;
  logic          busy_at0;

  task automatic run_burst(input logic [AW-1:0] base, input logic [AW-1:0] lm1,
                           input int ld_cyc, input int maxc);
    logic [AW-1:0] a_prev;
    a_prev = '0;
    beats.delete();
    addrs.delete();
    gnt_pos.delete();
    ndone = 0; done_at = -1; busy_low_at = -1; first_valid_at = -1; busy_at0 = 1'b1;
    brst_base   = base;
    brst_len_m1 = lm1;
    for (int k = 0; k <= maxc; k++) begin
      brst_start = (k == 0);
      ld_req     = (k < ld_cyc);
      @(negedge clk);
      if (k == 0) busy_at0 = brst_busy;
      if (rd_valid) begin
        beats.push_back(rd_data);
        addrs.push_back(a_prev);
        if (first_valid_at < 0) first_valid_at = k;
      end
      a_prev = ram_a;
      if (ld_gnt && k < ld_cyc) gnt_pos.push_back(k);
      if (brst_done) begin
        ndone++;
        done_at = k;
      end
      if (k > 0 && !brst_busy && busy_low_at < 0) busy_low_at = k;
      next_cycle();
    end
    brst_start = 1'b0;
    ld_req     = 1'b0;
  endtask

  function automatic logic [DW-1:0] beat_or_x(input int i);
    return (i < beats.size()) ? beats[i] : {DW{1'b1}};
  endfunction

  function automatic logic [DW-1:0] addr_or_x(input int i);
    return (i < addrs.size()) ? DW'(addrs[i]) : {DW{1'b1}};
  endfunction

  function automatic int gnt_or_x(input int i);
    return (i < gnt_pos.size()) ? gnt_pos[i] : -1;
  endfunction

  logic [DW-1:0] pat_a5, pat_z;
  int            dn;

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_z  = {8{32'hC0FF_EE05}};
    reset = 1'b1; ld_req = 1'b0; ld_addr = '0; ld_data = '0;
    brst_start = 1'b0; brst_base = '0; brst_len_m1 = '0;

    // Reset state
    next_cycle();
    @(negedge clk);
    check("rst_busy", DW'(brst_busy), '0);
    check("rst_valid", DW'(rd_valid), '0);
    check("rst_done", DW'(brst_done), '0);
    check("rst_gnt", DW'(ld_gnt), '0);
    check("rst_we", DW'(ram_we), '0);
    check("rst_a", DW'(ram_a), '0);
    next_cycle();
    reset = 1'b0;

    // Single write in IDLE is granted the same cycle
    ld_req = 1'b1; ld_addr = 4'd3; ld_data = pat_a5;
    @(negedge clk);
    check("wr_gnt", DW'(ld_gnt), 1);
    check("wr_we", DW'(ram_we), 1);
    check("wr_a", DW'(ram_a), 3);
    check("wr_d", ram_d, pat_a5);
    check("wr_busy", DW'(brst_busy), 0);
    next_cycle();
    ld_req = 1'b0;
    @(negedge clk);
    check("wr_gnt_drop", DW'(ld_gnt), 0);
    next_cycle();

    // Preload word k = k
    for (int k = 0; k < 16; k++) begin
      ld_req = 1'b1; ld_addr = AW'(k); ld_data = DW'(k);
      next_cycle();
    end
    ld_req = 1'b0;
    next_cycle();

    // Four-beat burst from 0
    run_burst(4'd0, 4'd3, 0, 8);
    check("b4_busy_t0", DW'(busy_at0), 0);
    check("b4_first_valid", DW'(first_valid_at), 2);
    check("b4_nbeats", DW'(beats.size()), 4);
    for (int i = 0; i < 4; i++) check($sformatf("b4_data%0d", i), beat_or_x(i), DW'(i));
    check("b4_done_at", DW'(done_at), 5);
    check("b4_ndone", DW'(ndone), 1);
    check("b4_busy_low", DW'(busy_low_at), 6);

    // Wrapping burst 14,15,0,1
    run_burst(4'd14, 4'd3, 0, 8);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap_a%0d", i), addr_or_x(i), DW'((14 + i) % 16));
      check($sformatf("wrap_d%0d", i), beat_or_x(i), DW'((14 + i) % 16));
    end
    check("wrap_done_at", DW'(done_at), 5);

    // Eight-beat burst with the loader requesting throughout (writes to word 12)
    ld_addr = 4'd12; ld_data = pat_a5;
    run_burst(4'd0, 4'd7, 17, 20);
    check("alt_ngnt", DW'(gnt_pos.size()), 9);
    for (int i = 0; i < 9; i++) check($sformatf("alt_gnt%0d", i), DW'(gnt_or_x(i)), DW'(2 * i));
    check("alt_nbeats", DW'(beats.size()), 8);
    for (int i = 0; i < 8; i++) check($sformatf("alt_data%0d", i), beat_or_x(i), DW'(i));
    check("alt_done_at", DW'(done_at), 16);
    check("alt_ndone", DW'(ndone), 1);

    // Read of 5 issued one cycle before a write to 5 returns the old data
    brst_base = 4'd5; brst_len_m1 = 4'd0; brst_start = 1'b1;
    next_cycle();
    brst_start = 1'b0;
    @(negedge clk);
    check("old_issue_a", DW'(ram_a), 5);
    check("old_issue_we", DW'(ram_we), 0);
    next_cycle();
    ld_req = 1'b1; ld_addr = 4'd5; ld_data = pat_z;
    @(negedge clk);
    check("old_drain_gnt", DW'(ld_gnt), 1);
    check("old_valid", DW'(rd_valid), 1);
    check("old_data", rd_data, DW'(5));
    check("old_done", DW'(brst_done), 1);
    next_cycle();
    ld_req = 1'b0;
    @(negedge clk);
    check("old_busy_low", DW'(brst_busy), 0);
    next_cycle();

    // Write to 5 and burst start together: the read next cycle sees new data
    ld_addr = 4'd5; ld_data = ~pat_z;
    run_burst(4'd5, 4'd0, 1, 4);
    check("raw_gnt", DW'(gnt_or_x(0)), 0);
    check("raw_data", beat_or_x(0), ~pat_z);
    check("raw_done_at", DW'(done_at), 2);

    // Reset after two beats of an eight-beat burst
    brst_base = 4'd0; brst_len_m1 = 4'd7; brst_start = 1'b1;
    next_cycle();
    brst_start = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("mid_busy", DW'(brst_busy), 0);
    check("mid_valid", DW'(rd_valid), 0);
    check("mid_done", DW'(brst_done), 0);
    dn = 0;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      @(negedge clk);
      if (brst_done || rd_valid || brst_busy) dn++;
    end
    check("mid_quiet", DW'(dn), 0);
    next_cycle();

    // Burst after the aborted one runs normally
    run_burst(4'd2, 4'd1, 0, 6);
    check("rec_nbeats", DW'(beats.size()), 2);
    check("rec_d0", beat_or_x(0), DW'(2));
    check("rec_d1", beat_or_x(1), DW'(3));
    check("rec_done_at", DW'(done_at), 3);
    check("rec_busy_low", DW'(busy_low_at), 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
